pi_loop_filter_gs: RTL

Second-generation digital PI loop filter for the ADPLL, between the phase/frequency detector error output and the DCO control-code input. It adds several behaviours on top of the first-generation filter:
- a valid-qualified input with a fixed two-cycle pipeline;
- a saturating integrator with anti-windup;
- a saturated output code;
- automatic gain gear-shifting from acquisition gains to tracking gains, driven by an on-chip lock detector.

---
 rtl/pi_loop_filter_gs_if.sv | 34 +++
 rtl/pi_loop_filter_gs.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pi_loop_filter_gs_if.sv
// -----------------------------------------------------------------------------
// pi_loop_filter_gs_if
// Bundle of the loop-filter data path signals between the phase/frequency
// detector side (master) and the PI loop filter (slave).
//   error_valid_i  : error_i carries a new sample this cycle
//   error_i        : signed phase error sample
//   hold_i         : freeze the integrator (outputs still update)
//   dco_cc_o       : signed DCO control code, registered
//   dco_cc_valid_o : one-cycle strobe when dco_cc_o updates
//   locked_o       : lock detector reports TRACK
//   sat_o          : last output code was clipped
// -----------------------------------------------------------------------------
interface pi_loop_filter_gs_if #(
    parameter int ERROR_WIDTH  = 5,
    parameter int DCO_CC_WIDTH = 5
);
    logic                           error_valid_i;
    logic signed [ERROR_WIDTH-1:0]  error_i;
    logic                           hold_i;
    logic signed [DCO_CC_WIDTH-1:0] dco_cc_o;
    logic                           dco_cc_valid_o;
    logic                           locked_o;
    logic                           sat_o;

    modport master (
        output error_valid_i, error_i, hold_i,
        input  dco_cc_o, dco_cc_valid_o, locked_o, sat_o
    );

    modport slave (
        input  error_valid_i, error_i, hold_i,
        output dco_cc_o, dco_cc_valid_o, locked_o, sat_o
    );
endinterface

// File: rtl/pi_loop_filter_gs.sv
// -----------------------------------------------------------------------------
// pi_loop_filter_gs
// Second-generation ADPLL PI loop filter: valid-qualified error input, a
// saturating integrator with anti-windup, a clipped DCO control code and
// (optionally) automatic acquisition->tracking gain gear-shifting driven by a
// lock detector.
//
// Ports:
//   gen_clk_i  : filter clock
//   reset_n_i  : asynchronous active-low reset
//   lf_if      : slave side of pi_loop_filter_gs_if (error in, DCO code out)
//
// Configuration macro:
//   LF_LOCK_DETECT_EN : when defined, the lock FSM, its counters and the gain
//                       gear-shift are built. When undefined, acquisition gains
//                       are used permanently and locked_o is tied low.
//
// Pipeline: sample registered at edge N (stage 1), integrator committed and
// code computed at edge N+1 (stage 2), output register/strobe at edge N+2.
// -----------------------------------------------------------------------------
module pi_loop_filter_gs #(
    parameter int ERROR_WIDTH    = 5,
    parameter int DCO_CC_WIDTH   = 5,
    parameter int KP_WIDTH       = 5,
    parameter int KI_WIDTH       = 7,
    parameter int ACCUM_OVERHEAD = 5,
    parameter int KP_ACQ         = 31,
    parameter int KI_ACQ         = 64,
    parameter int KP_TRK         = 8,
    parameter int KI_TRK         = 4,
    parameter int LOCK_THRESH    = 1,
    parameter int LOCK_COUNT     = 16,
    parameter int UNLOCK_COUNT   = 4
) (
    input  logic               gen_clk_i,
    input  logic               reset_n_i,
    pi_loop_filter_gs_if.slave lf_if
);

    localparam int IW       = ERROR_WIDTH + KI_WIDTH + ACCUM_OVERHEAD;
    localparam int SW       = ERROR_WIDTH + KI_WIDTH + 1;
    localparam int P_SHIFT  = KI_WIDTH - KP_WIDTH;
    localparam int CC_SHIFT = ERROR_WIDTH + KI_WIDTH - DCO_CC_WIDTH;
    // Width of the unclipped code: sum (SW+1 bits) shifted right by CC_SHIFT.
    localparam int CW       = DCO_CC_WIDTH + 2;

    localparam logic [KP_WIDTH-1:0] KP_ACQ_C = KP_WIDTH'(KP_ACQ);
    localparam logic [KI_WIDTH-1:0] KI_ACQ_C = KI_WIDTH'(KI_ACQ);
    localparam logic [KP_WIDTH-1:0] KP_TRK_C = KP_WIDTH'(KP_TRK);
    localparam logic [KI_WIDTH-1:0] KI_TRK_C = KI_WIDTH'(KI_TRK);

    localparam logic signed [IW-1:0] INTEG_MAX = {1'b0, {(IW-1){1'b1}}};
    localparam logic signed [IW-1:0] INTEG_MIN = {1'b1, {(IW-1){1'b0}}};
    localparam logic signed [DCO_CC_WIDTH-1:0] CC_MAX = {1'b0, {(DCO_CC_WIDTH-1){1'b1}}};
    localparam logic signed [DCO_CC_WIDTH-1:0] CC_MIN = {1'b1, {(DCO_CC_WIDTH-1){1'b0}}};

    // stage 1
    logic signed [ERROR_WIDTH-1:0]  e_r;
    logic [KP_WIDTH-1:0]            kp_r;
    logic [KI_WIDTH-1:0]            ki_r;
    logic                           v1_r;
    // stage 2
    logic signed [IW-1:0]           integ_r;
    logic signed [DCO_CC_WIDTH-1:0] cc_r;
    logic                           sat_r;
    logic                           v2_r;
    // outputs
    logic signed [DCO_CC_WIDTH-1:0] dco_cc_r;
    logic                           dco_cc_valid_r;
    logic                           sat_out_r;

    logic                           track_s;
    logic [KP_WIDTH-1:0]            kp_sel_s;
    logic [KI_WIDTH-1:0]            ki_sel_s;

    logic signed [SW-1:0]           e_ext_s;
    logic signed [SW-1:0]           kp_ext_s;
    logic signed [SW-1:0]           ki_ext_s;
    logic signed [SW-1:0]           prod_ki_s;
    logic signed [SW-1:0]           prod_kp_s;
    logic signed [SW-1:0]           p_s;
    logic signed [IW:0]             integ_sum_s;
    logic signed [IW-1:0]           integ_c_s;
    logic signed [SW-2:0]           integ_sh_s;
    logic signed [SW:0]             sum_s;
    logic signed [CW-1:0]           cc_s;
    logic                           clip_hi_s;
    logic                           clip_lo_s;
    logic signed [DCO_CC_WIDTH-1:0] cc_clip_s;
    logic                           windup_s;
    logic                           commit_s;

`ifdef LF_LOCK_DETECT_EN
    typedef enum logic {
        ST_ACQ   = 1'b0,
        ST_TRACK = 1'b1
    } lock_state_t;

    localparam int LC_W = $clog2(LOCK_COUNT + 1);
    localparam int UC_W = $clog2(UNLOCK_COUNT + 1);

    lock_state_t                state_r;
    logic [LC_W-1:0]            lock_cnt_r;
    logic [UC_W-1:0]            unlock_cnt_r;
    logic                       locked_r;
    logic [ERROR_WIDTH:0]       err_mag_s;
    logic                       in_lock_s;

    // |error_i| with one extra bit so the most negative code maps to +2^(W-1)
    always_comb begin
        err_mag_s = {1'b0, lf_if.error_i};
        if (lf_if.error_i[ERROR_WIDTH-1]) begin
            err_mag_s = {1'b0, ~lf_if.error_i} + {{ERROR_WIDTH{1'b0}}, 1'b1};
        end else begin
            err_mag_s = {1'b0, lf_if.error_i};
        end
        in_lock_s = (err_mag_s <= (ERROR_WIDTH+1)'(LOCK_THRESH));
    end

    // Lock detector FSM, advanced on every accepted sample
    always_ff @(posedge gen_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r      <= ST_ACQ;
            lock_cnt_r   <= '0;
            unlock_cnt_r <= '0;
            locked_r     <= 1'b0;
        end else if (lf_if.error_valid_i) begin
            case (state_r)
                ST_ACQ: begin
                    if (!in_lock_s) begin
                        lock_cnt_r <= '0;
                    end else if (lock_cnt_r == LC_W'(LOCK_COUNT - 1)) begin
                        lock_cnt_r   <= '0;
                        unlock_cnt_r <= '0;
                        state_r      <= ST_TRACK;
                        locked_r     <= 1'b1;
                    end else begin
                        lock_cnt_r <= lock_cnt_r + LC_W'(1);
                    end
                end
                ST_TRACK: begin
                    if (in_lock_s) begin
                        unlock_cnt_r <= '0;
                    end else if (unlock_cnt_r == UC_W'(UNLOCK_COUNT - 1)) begin
                        unlock_cnt_r <= '0;
                        lock_cnt_r   <= '0;
                        state_r      <= ST_ACQ;
                        locked_r     <= 1'b0;
                    end else begin
                        unlock_cnt_r <= unlock_cnt_r + UC_W'(1);
                    end
                end
                default: begin
                    state_r      <= ST_ACQ;
                    lock_cnt_r   <= '0;
                    unlock_cnt_r <= '0;
                    locked_r     <= 1'b0;
                end
            endcase
        end
    end

    assign track_s        = (state_r == ST_TRACK);
    assign lf_if.locked_o = locked_r;
`else
    assign track_s        = 1'b0;
    assign lf_if.locked_o = 1'b0;
`endif

    // Gain selection from the lock state seen by the sample being registered
    always_comb begin
        kp_sel_s = KP_ACQ_C;
        ki_sel_s = KI_ACQ_C;
        if (track_s) begin
            kp_sel_s = KP_TRK_C;
            ki_sel_s = KI_TRK_C;
        end else begin
            kp_sel_s = KP_ACQ_C;
            ki_sel_s = KI_ACQ_C;
        end
    end

    // Stage 1: capture the error sample and the gains it will be filtered with
    always_ff @(posedge gen_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            e_r  <= '0;
            kp_r <= '0;
            ki_r <= '0;
            v1_r <= 1'b0;
        end else begin
            v1_r <= lf_if.error_valid_i;
            if (lf_if.error_valid_i) begin
                e_r  <= lf_if.error_i;
                kp_r <= kp_sel_s;
                ki_r <= ki_sel_s;
            end
        end
    end

    // Stage 2 datapath: PI sum, integrator saturation, code clip, anti-windup
    always_comb begin
        e_ext_s   = {{(SW-ERROR_WIDTH){e_r[ERROR_WIDTH-1]}}, e_r};
        kp_ext_s  = {{(SW-KP_WIDTH){1'b0}}, kp_r};
        ki_ext_s  = {{(SW-KI_WIDTH){1'b0}}, ki_r};
        prod_ki_s = e_ext_s * ki_ext_s;
        prod_kp_s = e_ext_s * kp_ext_s;
        p_s       = prod_kp_s <<< P_SHIFT;

        // One guard bit detects integrator overflow; saturate instead of wrap.
        integ_sum_s = {integ_r[IW-1], integ_r}
                    + {{(IW+1-SW){prod_ki_s[SW-1]}}, prod_ki_s};
        if (integ_sum_s[IW] != integ_sum_s[IW-1]) begin
            integ_c_s = integ_sum_s[IW] ? INTEG_MIN : INTEG_MAX;
        end else begin
            integ_c_s = integ_sum_s[IW-1:0];
        end

        // Dropping the fraction bits is an arithmetic shift (floor).
        integ_sh_s = integ_c_s[IW-1:ACCUM_OVERHEAD];
        sum_s      = {p_s[SW-1], p_s} + {{2{integ_sh_s[SW-2]}}, integ_sh_s};
        cc_s       = sum_s[SW:CC_SHIFT];

        // In range only when the top three bits agree (sign + two guard bits).
        clip_hi_s = !cc_s[CW-1] && (cc_s[CW-1:CW-3] != 3'b000);
        clip_lo_s =  cc_s[CW-1] && (cc_s[CW-1:CW-3] != 3'b111);
        if (clip_hi_s) begin
            cc_clip_s = CC_MAX;
        end else if (clip_lo_s) begin
            cc_clip_s = CC_MIN;
        end else begin
            cc_clip_s = cc_s[DCO_CC_WIDTH-1:0];
        end

        // Stop integrating further into the direction that is already clipped.
        windup_s = (clip_hi_s || clip_lo_s) && (cc_s[CW-1] == prod_ki_s[SW-1]);
        commit_s = v1_r && !lf_if.hold_i && !windup_s;
    end

    // Stage 2 registers: integrator commit and the pending output code
    always_ff @(posedge gen_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            integ_r <= '0;
            cc_r    <= '0;
            sat_r   <= 1'b0;
            v2_r    <= 1'b0;
        end else begin
            v2_r <= v1_r;
            if (commit_s) begin
                integ_r <= integ_c_s;
            end
            if (v1_r) begin
                cc_r  <= cc_clip_s;
                sat_r <= clip_hi_s || clip_lo_s;
            end
        end
    end

    // Output registers: code and saturation flag hold between strobes
    always_ff @(posedge gen_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            dco_cc_r       <= '0;
            dco_cc_valid_r <= 1'b0;
            sat_out_r      <= 1'b0;
        end else begin
            dco_cc_valid_r <= v2_r;
            if (v2_r) begin
                dco_cc_r  <= cc_r;
                sat_out_r <= sat_r;
            end
        end
    end

    assign lf_if.dco_cc_o       = dco_cc_r;
    assign lf_if.dco_cc_valid_o = dco_cc_valid_r;
    assign lf_if.sat_o          = sat_out_r;

endmodule
